// File: rtl/csr_addr_pkg.sv
// Shared CSR register map of the accelerator core: register addresses and bit positions.
package csr_addr_pkg;

  localparam int unsigned CORE_SET_REG_ADDR            = 0;
  localparam int unsigned CORE_SET_START_CORE_BIT_ADDR = 0;
  localparam int unsigned CORE_SET_BUSY_BIT_ADDR       = 1;
  localparam int unsigned AM_PREDICT_REG_ADDR          = 2;
  localparam int unsigned AM_PREDICT_VALID_BIT_ADDR    = 8;

endpackage

// File: rtl/csr_seq_pkg.sv
// State encoding and shared constants of the CSR run sequencer.
package csr_seq_pkg;

  localparam int unsigned StateWidth = 4;
  localparam int unsigned PredWidth  = 8;

  typedef logic [StateWidth-1:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_CFG       = 4'd1;
  localparam state_t ST_START     = 4'd2;
  localparam state_t ST_POLL_WAIT = 4'd3;
  localparam state_t ST_POLL_REQ  = 4'd4;
  localparam state_t ST_POLL_RSP  = 4'd5;
  localparam state_t ST_PRED_REQ  = 4'd6;
  localparam state_t ST_PRED_RSP  = 4'd7;
  localparam state_t ST_DONE      = 4'd8;

endpackage

// File: rtl/csr_req_mux.sv
// Selects the CSR request source: config stream passthrough or sequencer-generated requests.
module csr_req_mux #(
  parameter int unsigned CsrDataWidth = 32,
  parameter int unsigned CsrAddrWidth = 32
) (
  input  logic                    sel_cfg,
  input  logic [CsrAddrWidth-1:0] cmd_addr,
  input  logic [CsrDataWidth-1:0] cmd_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CsrAddrWidth-1:0] seq_addr,
  input  logic [CsrDataWidth-1:0] seq_data,
  input  logic                    seq_write,
  input  logic                    seq_valid,
  output logic [CsrAddrWidth-1:0] req_addr,
  output logic [CsrDataWidth-1:0] req_data,
  output logic                    req_write,
  output logic                    req_valid,
  input  logic                    req_ready
);

  always_comb begin
    req_addr  = seq_addr;
    req_data  = seq_data;
    req_write = seq_write;
    req_valid = seq_valid;
    cmd_ready = 1'b0;
    if (sel_cfg) begin
      req_addr  = cmd_addr;
      req_data  = cmd_data;
      req_write = 1'b1;
      req_valid = cmd_valid;
      cmd_ready = req_ready;
    end
  end

endmodule

// File: rtl/csr_run_sequencer.sv
// Runs one accelerator job over CSR: forward config writes, start the core, poll BUSY,
// then read the prediction register and present the result.
module csr_run_sequencer
  import csr_addr_pkg::*;
  import csr_seq_pkg::*;
#(
  parameter int unsigned CsrDataWidth = 32,
  parameter int unsigned CsrAddrWidth = 32,
  parameter int unsigned PollInterval = 8,
  parameter int unsigned MaxPolls     = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [CsrAddrWidth-1:0] cmd_addr_i,
  input  logic [CsrDataWidth-1:0] cmd_data_i,
  input  logic                    cmd_last_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  output logic [CsrAddrWidth-1:0] csr_req_addr_o,
  output logic [CsrDataWidth-1:0] csr_req_data_o,
  output logic                    csr_req_write_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  input  logic [CsrDataWidth-1:0] csr_rsp_data_i,
  input  logic                    csr_rsp_valid_i,
  output logic                    csr_rsp_ready_o,
  output logic [PredWidth-1:0]    result_predict_o,
  output logic                    result_timeout_o,
  output logic                    result_invalid_o,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic                    busy_o
);

  localparam int unsigned PollCntW = $clog2(MaxPolls + 1);
  localparam int unsigned WaitCntW = $clog2(PollInterval + 1);

  localparam logic [CsrAddrWidth-1:0] CoreSetAddr   = CsrAddrWidth'(CORE_SET_REG_ADDR);
  localparam logic [CsrAddrWidth-1:0] AmPredictAddr = CsrAddrWidth'(AM_PREDICT_REG_ADDR);
  localparam logic [CsrDataWidth-1:0] StartData     =
    CsrDataWidth'(1) << CORE_SET_START_CORE_BIT_ADDR;
  localparam logic [WaitCntW-1:0]     WaitLast      = WaitCntW'(PollInterval - 1);
  localparam logic [PollCntW-1:0]     PollMax       = PollCntW'(MaxPolls);

  state_t                  state_q, state_d;
  logic [WaitCntW-1:0]     wait_q, wait_d;
  logic [PollCntW-1:0]     poll_q, poll_d;
  logic [PredWidth-1:0]    predict_q, predict_d;
  logic                    timeout_q, timeout_d;
  logic                    invalid_q, invalid_d;

  logic                    sel_cfg;
  logic [CsrAddrWidth-1:0] seq_addr;
  logic [CsrDataWidth-1:0] seq_data;
  logic                    seq_write;
  logic                    seq_valid;

  logic unused_rsp_bits;
  assign unused_rsp_bits = ^csr_rsp_data_i;

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      poll_q    <= '0;
      predict_q <= '0;
      timeout_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      poll_q    <= poll_d;
      predict_q <= predict_d;
      timeout_q <= timeout_d;
      invalid_q <= invalid_d;
    end
  end

  // Next-state, counter and request decode; request states hold valid until ready.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    poll_d    = poll_q;
    predict_d = predict_q;
    timeout_d = timeout_q;
    invalid_d = invalid_q;
    sel_cfg   = 1'b0;
    seq_addr  = '0;
    seq_data  = '0;
    seq_write = 1'b0;
    seq_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) state_d = ST_CFG;
      end
      ST_CFG: begin
        sel_cfg = 1'b1;
        if (cmd_valid_i && csr_req_ready_i && cmd_last_i) state_d = ST_START;
      end
      ST_START: begin
        seq_addr  = CoreSetAddr;
        seq_data  = StartData;
        seq_write = 1'b1;
        seq_valid = 1'b1;
        if (csr_req_ready_i) begin
          state_d = ST_POLL_WAIT;
          wait_d  = '0;
        end
      end
      ST_POLL_WAIT: begin
        if (wait_q == WaitLast) begin
          state_d = ST_POLL_REQ;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WaitCntW'(1);
        end
      end
      ST_POLL_REQ: begin
        seq_addr  = CoreSetAddr;
        seq_valid = 1'b1;
        if (csr_req_ready_i) begin
          state_d = ST_POLL_RSP;
          if (poll_q != PollMax) poll_d = poll_q + PollCntW'(1);
        end
      end
      ST_POLL_RSP: begin
        if (csr_rsp_valid_i) begin
          if (!csr_rsp_data_i[CORE_SET_BUSY_BIT_ADDR]) begin
            state_d = ST_PRED_REQ;
          end else if (poll_q == PollMax) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end else begin
            state_d = ST_POLL_WAIT;
          end
        end
      end
      ST_PRED_REQ: begin
        seq_addr  = AmPredictAddr;
        seq_valid = 1'b1;
        if (csr_req_ready_i) state_d = ST_PRED_RSP;
      end
      ST_PRED_RSP: begin
        if (csr_rsp_valid_i) begin
          state_d   = ST_DONE;
          predict_d = csr_rsp_data_i[PredWidth-1:0];
          invalid_d = ~csr_rsp_data_i[AM_PREDICT_VALID_BIT_ADDR];
        end
      end
      ST_DONE: begin
        if (result_ready_i) begin
          state_d   = ST_IDLE;
          poll_d    = '0;
          predict_d = '0;
          timeout_d = 1'b0;
          invalid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  csr_req_mux #(
    .CsrDataWidth(CsrDataWidth),
    .CsrAddrWidth(CsrAddrWidth)
  ) u_req_mux (
    .sel_cfg  (sel_cfg),
    .cmd_addr (cmd_addr_i),
    .cmd_data (cmd_data_i),
    .cmd_valid(cmd_valid_i),
    .cmd_ready(cmd_ready_o),
    .seq_addr (seq_addr),
    .seq_data (seq_data),
    .seq_write(seq_write),
    .seq_valid(seq_valid),
    .req_addr (csr_req_addr_o),
    .req_data (csr_req_data_o),
    .req_write(csr_req_write_o),
    .req_valid(csr_req_valid_o),
    .req_ready(csr_req_ready_i)
  );

  assign csr_rsp_ready_o  = (state_q == ST_POLL_RSP) || (state_q == ST_PRED_RSP);
  assign result_valid_o   = (state_q == ST_DONE);
  assign busy_o           = (state_q != ST_IDLE);
  assign result_predict_o = predict_q;
  assign result_timeout_o = timeout_q;
  assign result_invalid_o = invalid_q;

endmodule

// File: tb/tb_csr_run_sequencer.sv
// Scoreboard bench: jobs push expected CSR requests and results; slave and result monitors compare.
module tb_csr_run_sequencer;
  import csr_addr_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned PI = 3;
  localparam int unsigned MP = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [DW-1:0] cmd_data_i = '0;
  logic          cmd_last_i = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] csr_req_addr_o;
  logic [DW-1:0] csr_req_data_o;
  logic          csr_req_write_o;
  logic          csr_req_valid_o;
  logic          csr_req_ready_i;
  logic [DW-1:0] csr_rsp_data_i;
  logic          csr_rsp_valid_i;
  logic          csr_rsp_ready_o;
  logic [7:0]    result_predict_o;
  logic          result_timeout_o;
  logic          result_invalid_o;
  logic          result_valid_o;
  logic          result_ready_i;
  logic          busy_o;

  csr_run_sequencer #(
    .CsrDataWidth(DW), .CsrAddrWidth(AW), .PollInterval(PI), .MaxPolls(MP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_last_i(cmd_last_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .csr_req_addr_o(csr_req_addr_o), .csr_req_data_o(csr_req_data_o),
    .csr_req_write_o(csr_req_write_o), .csr_req_valid_o(csr_req_valid_o),
    .csr_req_ready_i(csr_req_ready_i),
    .csr_rsp_data_i(csr_rsp_data_i), .csr_rsp_valid_i(csr_rsp_valid_i),
    .csr_rsp_ready_o(csr_rsp_ready_o),
    .result_predict_o(result_predict_o), .result_timeout_o(result_timeout_o),
    .result_invalid_o(result_invalid_o), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic write; } req_t;
  typedef struct { logic [7:0] predict; logic timeout; logic invalid; } res_t;
  req_t exp_q[$];
  res_t res_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int          ready_lat = 0, rsp_lat = 0, res_lat = 0;
  int          busy_polls = 0, polls_seen = 0;
  logic [31:0] pred_rsp = '0;
  bit          stray = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // CSR slave: random/fixed ready latency, delayed responses, request scoreboard.
  initial begin : slave
    logic [127:0] held;
    bit           prev_pend, pending, hs_req, hs_rsp;
    int           wait_cnt, rsp_cnt;
    logic [31:0]  rsp_val;
    req_t         e;
    prev_pend = 0; pending = 0; wait_cnt = 0; rsp_cnt = 0; rsp_val = '0; held = '0;
    csr_req_ready_i = 1'b0; csr_rsp_valid_i = 1'b0; csr_rsp_data_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        prev_pend = 0; pending = 0; wait_cnt = 0;
      end else begin
        hs_req = csr_req_valid_o && csr_req_ready_i;
        hs_rsp = csr_rsp_valid_i && csr_rsp_ready_o;
        if (prev_pend) begin
          check("req_valid_held", 128'(csr_req_valid_o), 128'(1));
          check("req_fields_stable", {63'b0, csr_req_addr_o, csr_req_data_o, csr_req_write_o}, held);
        end
        prev_pend = csr_req_valid_o && !csr_req_ready_i;
        held = {63'b0, csr_req_addr_o, csr_req_data_o, csr_req_write_o};
        if (hs_req) begin
          wait_cnt = 0;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_req: actual addr 0x%0h write %0b, required no request",
                     csr_req_addr_o, csr_req_write_o);
          end else begin
            e = exp_q.pop_front();
            check("req_addr", 128'(csr_req_addr_o), 128'(e.addr));
            check("req_write", 128'(csr_req_write_o), 128'(e.write));
            if (e.write) check("req_data", 128'(csr_req_data_o), 128'(e.data));
          end
          if (!csr_req_write_o) begin
            check("single_outstanding", 128'(pending), 128'(0));
            pending = 1; rsp_cnt = rsp_lat;
            if (csr_req_addr_o == 2) rsp_val = pred_rsp;
            else begin
              rsp_val = $urandom;
              rsp_val[CORE_SET_BUSY_BIT_ADDR] = (polls_seen < busy_polls);
              polls_seen++;
            end
          end
        end
        if (hs_rsp) pending = 0;
      end
      @(posedge clk); #2;
      if (!rst_ni) begin
        csr_req_ready_i = 1'b0; csr_rsp_valid_i = 1'b0;
      end else begin
        if (csr_req_valid_o && wait_cnt >= ready_lat) csr_req_ready_i = 1'b1;
        else begin
          csr_req_ready_i = 1'b0;
          if (csr_req_valid_o) wait_cnt++;
        end
        if (pending) begin
          if (rsp_cnt == 0) begin csr_rsp_valid_i = 1'b1; csr_rsp_data_i = rsp_val; end
          else begin rsp_cnt--; csr_rsp_valid_i = 1'b0; end
        end else begin
          csr_rsp_valid_i = stray;
          csr_rsp_data_i  = $urandom;
        end
      end
    end
  end

  // Result monitor: stability while waiting, cmd_ready low in DONE, scoreboard pop on handshake.
  initial begin : result_mon
    logic [9:0] first;
    bit         have_first;
    int         hold;
    res_t       r;
    have_first = 0; hold = 0; first = '0;
    result_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        have_first = 0; hold = 0;
      end else if (result_valid_o) begin
        check("cmd_ready_in_done", 128'(cmd_ready_o), 128'(0));
        if (have_first)
          check("result_stable", 128'({result_predict_o, result_timeout_o, result_invalid_o}),
                128'(first));
        else begin
          first = {result_predict_o, result_timeout_o, result_invalid_o};
          have_first = 1;
        end
        if (result_ready_i) begin
          have_first = 0; hold = 0;
          if (res_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_result: actual predict 0x%0h, required no result",
                     result_predict_o);
          end else begin
            r = res_q.pop_front();
            check("result_predict", 128'(result_predict_o), 128'(r.predict));
            check("result_timeout", 128'(result_timeout_o), 128'(r.timeout));
            check("result_invalid", 128'(result_invalid_o), 128'(r.invalid));
          end
        end
      end
      @(posedge clk); #2;
      if (!rst_ni) result_ready_i = 1'b0;
      else if (result_valid_o && !result_ready_i) begin
        if (hold >= res_lat) result_ready_i = 1'b1;
        else hold++;
      end else result_ready_i = 1'b0;
    end
  end

  // Reference model of one job: expected CSR traffic and result from the job parameters.
  task automatic send_job(input int ncmd, input int bpolls, input logic [31:0] pred, input bit fixed_addr);
    logic [AW-1:0] a[];
    logic [DW-1:0] d[];
    int nreads;
    bit to;
    a = new[ncmd]; d = new[ncmd];
    for (int i = 0; i < ncmd; i++) begin
      a[i] = fixed_addr ? AW'(13 + i) : AW'($urandom_range(3, 255));
      d[i] = $urandom;
      exp_q.push_back('{addr: a[i], data: d[i], write: 1'b1});
    end
    exp_q.push_back('{addr: 0, data: 32'h1, write: 1'b1});
    to = (bpolls >= MP);
    nreads = to ? MP : bpolls + 1;
    for (int i = 0; i < nreads; i++) exp_q.push_back('{addr: 0, data: 0, write: 1'b0});
    if (!to) exp_q.push_back('{addr: 2, data: 0, write: 1'b0});
    res_q.push_back('{predict: to ? 8'h00 : pred[7:0], timeout: to, invalid: to ? 1'b0 : ~pred[8]});
    busy_polls = bpolls; polls_seen = 0; pred_rsp = pred;
    for (int i = 0; i < ncmd; i++) begin
      int c;
      @(posedge clk); #1;
      cmd_addr_i = a[i]; cmd_data_i = d[i]; cmd_last_i = (i == ncmd - 1); cmd_valid_i = 1'b1;
      for (c = 0; c < 200; c++) begin
        @(negedge clk);
        if (cmd_valid_i && cmd_ready_o) break;
      end
      if (c == 200) begin
        n_checks++; n_fail++;
        $display("FAIL cmd_accept_timeout: actual no handshake, required handshake within 200 cycles");
      end
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0; cmd_last_i = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && (res_q.size() == 0) && !busy_o;
    end
    check("job_complete", 128'(ok), 128'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 128'({cmd_ready_o, csr_req_valid_o, csr_rsp_ready_o, result_valid_o, busy_o,
                     result_predict_o, result_timeout_o, result_invalid_o}), 128'(0));
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #3 rst_ni = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_outputs");

    stray = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stray_rsp_ready", 128'(csr_rsp_ready_o), 128'(0));
      check("stray_idle", 128'({busy_o, csr_req_valid_o}), 128'(0));
    end
    stray = 1'b0;

    send_job(3, 3, 32'h12A, 1'b1);
    @(negedge clk);
    check("busy_during_job", 128'(busy_o), 128'(1));
    wait_done();

    send_job(2, 10, 32'h1FF, 1'b0);
    wait_done();

    send_job(1, 0, 32'h05, 1'b0);
    wait_done();

    ready_lat = 10; rsp_lat = 5;
    send_job(3, 2, 32'h1C3, 1'b0);
    wait_done();
    ready_lat = 0; rsp_lat = 0;

    res_lat = 20;
    send_job(2, 1, 32'h177, 1'b0);
    for (int c = 0; c < 500 && !result_valid_o; c++) @(negedge clk);
    check("reached_done", 128'(result_valid_o), 128'(1));
    @(posedge clk); #1 cmd_valid_i = 1'b1; cmd_addr_i = 'h55;
    repeat (15) @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    wait_done();
    res_lat = 0;

    rsp_lat = 3;
    send_job(2, 2, 32'h1AA, 1'b0);
    for (int c = 0; c < 500 && !csr_rsp_ready_o; c++) @(negedge clk);
    check("reached_poll_rsp", 128'(csr_rsp_ready_o), 128'(1));
    @(posedge clk); #3 rst_ni = 1'b0;
    @(negedge clk);
    exp_q.delete(); res_q.delete();
    check_all_zero("mid_job_reset_outputs");
    repeat (2) @(posedge clk);
    #3 rst_ni = 1'b1;
    rsp_lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_replay_idle", 128'({busy_o, csr_req_valid_o}), 128'(0));
    end
    send_job(2, 1, 32'h1E4, 1'b0);
    wait_done();

    for (int j = 0; j < 6; j++) begin
      ready_lat = $urandom_range(0, 3);
      rsp_lat   = $urandom_range(0, 3);
      res_lat   = $urandom_range(0, 3);
      send_job($urandom_range(1, 4), $urandom_range(0, 5), $urandom & 32'h1FF, 1'b0);
      wait_done();
    end

    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_run_sequencer.md
CSR_RUN_SEQUENCER -- requirements
Module: csr_run_sequencer

Interface
REQ-001 Parameter CsrDataWidth, default 32: CSR data width.
REQ-002 Parameter CsrAddrWidth, default 32: CSR address width.
REQ-003 Parameter PollInterval, default 8: idle cycles between BUSY polls, minimum 1.
REQ-004 Parameter MaxPolls, default 1024: poll reads before timeout.
REQ-005 The clock SHALL be clk_i; reset SHALL be rst_ni, asynchronous, active-low; one clock domain.
REQ-006 Ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- cmd_addr_i  in  CsrAddrWidth  config write address
- cmd_data_i  in  CsrDataWidth  config write data
- cmd_last_i  in  1  final config write of a job
- cmd_valid_i / cmd_ready_o  in/out  1  config stream handshake
- csr_req_addr_o  out  CsrAddrWidth  CSR request address
- csr_req_data_o  out  CsrDataWidth  CSR write data
- csr_req_write_o  out  1  1 = write, 0 = read
- csr_req_valid_o / csr_req_ready_i  out/in  1  CSR request handshake
- csr_rsp_data_i  in  CsrDataWidth  CSR read data
- csr_rsp_valid_i / csr_rsp_ready_o  in/out  1  CSR read-response handshake
- result_predict_o  out  8  AM prediction
- result_timeout_o  out  1  core never went idle
- result_invalid_o  out  1  prediction valid bit was clear
- result_valid_i... no: result_valid_o / result_ready_i  out/in  1  result handshake
- busy_o  out  1  high in any state except IDLE

Function
REQ-007 The states SHALL be IDLE, CFG, START, POLL_WAIT, POLL_REQ, POLL_RSP, PRED_REQ, PRED_RSP, DONE.
REQ-008 IDLE SHALL go to CFG when cmd_valid_i=1; no CSR traffic in IDLE.
REQ-009 In CFG, cmd_* SHALL pass combinationally to csr_req_* with write=1, and cmd_ready_o=csr_req_ready_i; a handshake with cmd_last_i=1 SHALL go to START.
REQ-010 START SHALL issue one write: address CORE_SET_REG_ADDR, data with only bit CORE_SET_START_CORE_BIT_ADDR set; on handshake go to POLL_WAIT.
REQ-011 POLL_WAIT SHALL count PollInterval cycles, then go to POLL_REQ.
REQ-012 POLL_REQ SHALL issue a read of CORE_SET_REG_ADDR; on handshake go to POLL_RSP and increment the poll counter.
REQ-013 POLL_RSP SHALL assert csr_rsp_ready_o; when bit CORE_SET_BUSY_BIT_ADDR=0 go to PRED_REQ.
REQ-014 Otherwise, if the poll counter equals MaxPolls, POLL_RSP SHALL go to DONE with result_timeout_o=1; else go back to POLL_WAIT.
REQ-015 PRED_REQ SHALL read AM_PREDICT_REG_ADDR. PRED_RSP SHALL capture bits [7:0] into result_predict_o and set result_invalid_o to the inverse of bit AM_PREDICT_VALID_BIT_ADDR, then go to DONE.
REQ-016 DONE SHALL hold result_valid_o=1 with stable result outputs until result_ready_i; then go to IDLE and clear the poll counter and flags.
REQ-017 Each request SHALL hold addr, data and write stable from valid until ready, and valid SHALL never drop before ready (AXI-style).
REQ-018 At most one request SHALL be outstanding; no new request until the read response is accepted.
REQ-019 csr_rsp_ready_o SHALL be 0 outside POLL_RSP and PRED_RSP; a stray response elsewhere is ignored.
REQ-020 cmd_ready_o SHALL be 0 outside CFG; cmd_valid_i is ignored during a job.
REQ-021 A CFG write with cmd_last_i=1 SHALL still be forwarded before START.
REQ-022 The poll counter SHALL be clog2(MaxPolls+1) bits and SHALL saturate, never wrap.
REQ-023 A response arriving in the same cycle as its request handshake SHALL NOT be accepted; responses are taken from the next cycle on.

Reset
REQ-024 Asserting rst_ni SHALL, at any time including mid-transaction, force IDLE and zero all counters and result registers.
REQ-025 During and after reset, all valid/ready outputs, busy_o and result_* outputs SHALL be 0.
REQ-026 An abandoned CSR transaction SHALL NOT be replayed after reset.

Structure
REQ-027 CSR register/bit addresses SHALL come from the shared CSR address package.
REQ-028 The state enum typedef SHALL live in a shared package (e.g. csr_seq_pkg).
REQ-029 One sub-module csr_req_mux SHALL select the request source (CFG passthrough vs. internal sequencer requests); the FSM, counters and result registers stay in the top.

Verification
REQ-030 Three cmds (addr 13/14/15, last on the third), core busy for 3 polls -> 3 writes, write addr 0 data 0x1, 4 reads of addr 0, read of addr 2; rsp 0x12A -> predict 0x2A, invalid 0, timeout 0.
REQ-031 MaxPolls=4, BUSY stuck at 1 -> exactly 4 reads of addr 0, then result_timeout_o=1 and no read of addr 2.
REQ-032 AM_PREDICT rsp 0x05 (bit 8 clear) -> predict 0x05, result_invalid_o=1.
REQ-033 csr_req_ready_i held low 10 cycles per request, rsp_valid delayed 5 cycles -> request fields stable, no dropped or duplicated requests.
REQ-034 rst_ni pulsed during POLL_RSP -> all outputs 0 next cycle; a new job runs cleanly from IDLE.
REQ-035 result_ready_i held low 20 cycles -> result stable and cmd_ready_o=0 for all 20 cycles.
